// File: rtl/sha256_ctrl_pkg.sv
// Shared state encoding and block-layout constants for the SHA-256 sequencer
// that feeds the Kyber hash_h path.
package sha256_ctrl_pkg;

  localparam int BLOCK_WORDS  = 16;
  localparam int DIGEST_WORDS = 8;
  localparam int BLK_W        = $clog2(BLOCK_WORDS);
  localparam int FCNT_W       = $clog2(DIGEST_WORDS);

  localparam logic [31:0]      PAD_WORD = 32'h8000_0000;
  localparam logic [BLK_W-1:0] LEN_POS  = BLK_W'(14);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_INIT   = 4'd1,
    ST_MSG    = 4'd2,
    ST_PAD    = 4'd3,
    ST_ZERO   = 4'd4,
    ST_LEN_HI = 4'd5,
    ST_LEN_LO = 4'd6,
    ST_FETCH  = 4'd7,
    ST_DONE   = 4'd8
  } state_e;

endpackage

// File: rtl/sha256_pad_gen.sv
// Combinational padding generator: word to offer and the follow-on state for
// the PAD / ZERO / LEN_HI / LEN_LO phases of the SHA-256 message schedule.
module sha256_pad_gen
  import sha256_ctrl_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  state_e             state_i,
  input  logic [BLK_W-1:0]   blk_pos_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic [31:0]        word_o,
  output logic               gen_o,
  output state_e             next_o
);

  logic [BLK_W-1:0] pos_next;
  logic [31:0]      len_bits;

  assign pos_next = blk_pos_i + BLK_W'(1);
  // Message length in bits; LEN_W <= 27 keeps this inside 32 bits.
  assign len_bits = 32'(len_i) << 5;

  // Zero fill keeps going through a block wrap until the length slot of the
  // final block, which covers messages ending in the last two block words.
  always_comb begin
    word_o = '0;
    gen_o  = 1'b0;
    next_o = state_i;
    case (state_i)
      ST_PAD: begin
        word_o = PAD_WORD;
        gen_o  = 1'b1;
        next_o = (pos_next == LEN_POS) ? ST_LEN_HI : ST_ZERO;
      end
      ST_ZERO: begin
        gen_o  = 1'b1;
        next_o = (pos_next == LEN_POS) ? ST_LEN_HI : ST_ZERO;
      end
      ST_LEN_HI: begin
        gen_o  = 1'b1;
        next_o = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        word_o = len_bits;
        gen_o  = 1'b1;
        next_o = ST_FETCH;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sha256_ctrl.sv
// Sequencer between hash_h / KEM controller and the SHA-256 core: init, message
// words, padding and length words, then an 8-word digest fetch.
module sha256_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_words,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              busy,
  output logic              done,
  output logic [255:0]      digest,
  output logic              core_init,
  output logic              core_load,
  output logic [31:0]       core_idata,
  output logic              core_fetch,
  input  logic              core_ack,
  input  logic [31:0]       core_odata,
  output state_e            dbg_state_o
);

  // Handshakes: a word moves on in_valid&&in_ready (message side) and on
  // core_load&&core_ack / core_fetch&&core_ack (core side); an offered word
  // and its data stay put until that cycle.

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic [BLK_W-1:0]    blk_pos_q, blk_pos_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [255:0]        digest_q, digest_d;

  logic [31:0]         gen_word;
  logic                gen_valid;
  state_e              gen_next;

  sha256_pad_gen #(.LEN_W(LEN_W)) u_pad_gen (
    .state_i   (state_q),
    .blk_pos_i (blk_pos_q),
    .len_i     (len_q),
    .word_o    (gen_word),
    .gen_o     (gen_valid),
    .next_o    (gen_next)
  );

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    core_init  = (state_q == ST_INIT);
    core_fetch = (state_q == ST_FETCH);
    in_ready   = (state_q == ST_MSG) && core_ack;
    core_load  = 1'b0;
    core_idata = '0;
    if (state_q == ST_MSG) begin
      core_load  = in_valid;
      core_idata = in_data;
    end else if (gen_valid) begin
      core_load  = 1'b1;
      core_idata = gen_word;
    end
  end

  assign digest      = digest_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    remain_d  = remain_q;
    blk_pos_d = blk_pos_q;
    fcnt_d    = fcnt_q;
    digest_d  = digest_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_INIT;
          len_d     = msg_words;
          remain_d  = msg_words;
          blk_pos_d = '0;
          fcnt_d    = '0;
        end
      end
      ST_INIT: state_d = (len_q != '0) ? ST_MSG : ST_PAD;
      ST_MSG: begin
        if (in_valid && core_ack) begin
          remain_d  = remain_q - LEN_W'(1);
          blk_pos_d = blk_pos_q + BLK_W'(1);
          if (remain_q == LEN_W'(1)) state_d = ST_PAD;
        end
      end
      ST_PAD, ST_ZERO, ST_LEN_HI, ST_LEN_LO: begin
        if (core_ack) begin
          blk_pos_d = blk_pos_q + BLK_W'(1);
          state_d   = gen_next;
        end
      end
      ST_FETCH: begin
        if (core_ack) begin
          // H0 lands in the top word, H7 in the bottom word.
          for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (fcnt_q == FCNT_W'(i)) digest_d[(DIGEST_WORDS-1-i)*32 +: 32] = core_odata;
          end
          fcnt_d = fcnt_q + FCNT_W'(1);
          if (fcnt_q == FCNT_W'(DIGEST_WORDS-1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      remain_q  <= '0;
      blk_pos_q <= '0;
      fcnt_q    <= '0;
      digest_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      remain_q  <= remain_d;
      blk_pos_q <= blk_pos_d;
      fcnt_q    <= fcnt_d;
      digest_q  <= digest_d;
    end
  end

  a_load_fetch_excl: assert property (@(posedge clk) disable iff (!reset_n)
    !(core_load && core_fetch));

  a_gen_word_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (core_load && !core_ack && state_q != ST_MSG) |=> (core_load && $stable(core_idata)));

endmodule

// File: tb/tb_sha256_ctrl.sv
// Directed bench for sha256_ctrl with a behavioural SHA-256 core responder.
module tb_sha256_ctrl;
  import sha256_ctrl_pkg::*;

  localparam int LEN_W = 10;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_words = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             busy, done;
  logic [255:0]     digest;
  logic             core_init, core_load, core_fetch;
  logic [31:0]      core_idata;
  logic             core_ack = 1'b0;
  logic [31:0]      core_odata = '0;
  state_e           dbg_state;

  sha256_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .msg_words(msg_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .digest(digest),
    .core_init(core_init), .core_load(core_load), .core_idata(core_idata),
    .core_fetch(core_fetch), .core_ack(core_ack), .core_odata(core_odata),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
  endfunction

  // ---------------- stimulus settings (written by tests) ----------------
  logic [31:0] msg_mem [256];
  int          feed_len   = 0;
  bit          stall_mode = 1'b0;
  bit          gap_mode   = 1'b0;

  // ---------------- scoreboard ----------------
  logic [31:0]  exp_q [$];
  logic [255:0] exp_digest;
  int           n_checks = 0;
  int           n_pass   = 0;

  // ---------------- core responder / message feeder ----------------
  int           feed_idx = 0;
  bit           fed = 1'b0;
  bit           ld_pending = 1'b0;
  logic [31:0]  ld_pend_word = '0;
  logic [31:0]  load_log [512];
  int           load_cnt = 0;
  int           init_cnt = 0;
  int           done_cnt = 0;
  int           stab_err = 0;
  int           both_err = 0;
  logic [255:0] h_model = '0;
  logic [511:0] blk_model = '0;
  int           wcnt = 0;
  int           fidx = 0;

  // Inputs change on the falling edge; handshakes are recorded 1 time unit
  // later, which is the transfer that completes on the next rising edge.
  always @(negedge clk) begin
    if (fed) in_valid = 1'b0;
    fed = 1'b0;
    if (!reset_n || feed_idx >= feed_len) in_valid = 1'b0;
    core_ack = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!in_valid && reset_n && feed_idx < feed_len)
      in_valid = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    in_data    = (feed_idx < 256) ? msg_mem[feed_idx] : 32'h0;
    core_odata = (fidx < 8) ? h_model[255-32*fidx -: 32] : 32'h0;
    #1;
    if (!reset_n) begin
      ld_pending = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        feed_idx++;
        fed = 1'b1;
      end
      if (core_load && core_fetch) both_err++;
      if (ld_pending && (!core_load || core_idata !== ld_pend_word)) stab_err++;
      ld_pending   = core_load && !core_ack;
      ld_pend_word = core_idata;
      if (core_load && core_ack) begin
        if (load_cnt < 512) load_log[load_cnt] = core_idata;
        load_cnt++;
        blk_model = {blk_model[479:0], core_idata};
        wcnt++;
        if (wcnt == 16) begin
          h_model = compress(h_model, blk_model);
          wcnt = 0;
        end
      end
      if (core_fetch && core_ack) fidx++;
      if (core_init) begin
        h_model  = IV;
        wcnt     = 0;
        fidx     = 0;
        load_cnt = 0;
        feed_idx = 0;
        init_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic build_expected(input int len);
    logic [255:0] h;
    logic [511:0] blk;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(msg_mem[i]);
    exp_q.push_back(32'h8000_0000);
    while ((exp_q.size() % 16) != 14) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'(len) * 32);
    h = IV;
    for (int b = 0; b < exp_q.size() / 16; b++) begin
      for (int j = 0; j < 16; j++) blk = {blk[479:0], exp_q[b*16+j]};
      h = compress(h, blk);
    end
    exp_digest = h;
  endtask

  task automatic drive_hash(input int len, input int poke_at, output bit ok);
    feed_len = len;
    @(negedge clk);
    msg_words = LEN_W'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (cyc == poke_at) begin
        start = 1'b1;
        msg_words = LEN_W'(3);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic int count_word_diffs();
    int m = 0;
    for (int i = 0; i < exp_q.size(); i++) if (load_log[i] !== exp_q[i]) m++;
    return m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, in_ready, core_init, core_load, core_fetch} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000", {busy, done, in_ready, core_init, core_load, core_fetch});
    else n_pass++;
    n_checks++;
    if (core_idata !== 32'h0 || digest !== 256'h0)
      $display("FAIL reset_data: idata %h digest %h required zero", core_idata, digest);
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL reset_idle: busy %b state %0d required 0 / IDLE", busy, dbg_state);
    else n_pass++;
  endtask

  task automatic test_empty();
    bit ok;
    int i0 = init_cnt, d0 = done_cnt;
    stall_mode = 1'b0; gap_mode = 1'b0;
    build_expected(0);
    drive_hash(0, -1, ok);
    n_checks++;
    if (!ok || load_cnt !== 16) $display("FAIL empty_loads: ok %b loads %0d required 16", ok, load_cnt);
    else n_pass++;
    n_checks++;
    if (count_word_diffs() !== 0) $display("FAIL empty_words: %0d wrong words required 0", count_word_diffs());
    else n_pass++;
    n_checks++;
    if (digest !== EMPTY_DIGEST) $display("FAIL empty_digest: got %h required %h", digest, EMPTY_DIGEST);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (init_cnt - i0 !== 1 || done_cnt - d0 !== 1 || busy !== 1'b0)
      $display("FAIL empty_pulses: init %0d done %0d busy %b required 1 1 0", init_cnt - i0, done_cnt - d0, busy);
    else n_pass++;
  endtask

  task automatic test_len8();
    bit ok;
    for (int i = 0; i < 8; i++) msg_mem[i] = 32'(i);
    build_expected(8);
    drive_hash(8, -1, ok);
    n_checks++;
    if (!ok || load_cnt !== 16) $display("FAIL l8_loads: ok %b loads %0d required 16", ok, load_cnt);
    else n_pass++;
    n_checks++;
    if (load_log[7] !== 32'h7 || load_log[8] !== 32'h8000_0000 || load_log[14] !== 32'h0 || load_log[15] !== 32'h100)
      $display("FAIL l8_tail: words %h %h %h %h required 7 80000000 0 100", load_log[7], load_log[8], load_log[14], load_log[15]);
    else n_pass++;
    n_checks++;
    if (count_word_diffs() !== 0) $display("FAIL l8_words: %0d wrong words required 0", count_word_diffs());
    else n_pass++;
    n_checks++;
    if (digest !== exp_digest) $display("FAIL l8_digest: got %h required %h", digest, exp_digest);
    else n_pass++;
  endtask

  task automatic test_block_boundary();
    bit ok;
    int zeros;
    for (int i = 0; i < 16; i++) msg_mem[i] = 32'(i + 1) * 32'h0101_0101;
    build_expected(14);
    drive_hash(14, -1, ok);
    n_checks++;
    if (!ok || load_cnt !== 32) $display("FAIL l14_loads: ok %b loads %0d required 32", ok, load_cnt);
    else n_pass++;
    zeros = 0;
    for (int i = 15; i <= 30; i++) if (load_log[i] === 32'h0) zeros++;
    n_checks++;
    if (load_log[14] !== 32'h8000_0000 || zeros !== 16 || load_log[31] !== 32'h1C0)
      $display("FAIL l14_pad: w14 %h zeros %0d w31 %h required 80000000 16 000001c0", load_log[14], zeros, load_log[31]);
    else n_pass++;
    n_checks++;
    if (digest !== exp_digest) $display("FAIL l14_digest: got %h required %h", digest, exp_digest);
    else n_pass++;
    build_expected(13);
    drive_hash(13, -1, ok);
    n_checks++;
    if (!ok || load_cnt !== 16 || load_log[13] !== 32'h8000_0000 || load_log[15] !== 32'h1A0)
      $display("FAIL l13_loads: ok %b loads %0d w13 %h w15 %h required 16 80000000 000001a0", ok, load_cnt, load_log[13], load_log[15]);
    else n_pass++;
    n_checks++;
    if (digest !== exp_digest) $display("FAIL l13_digest: got %h required %h", digest, exp_digest);
    else n_pass++;
  endtask

  task automatic test_long_stalls();
    bit ok;
    int s0 = stab_err, b0 = both_err;
    for (int i = 0; i < 200; i++) msg_mem[i] = $urandom;
    stall_mode = 1'b1; gap_mode = 1'b1;
    build_expected(200);
    drive_hash(200, -1, ok);
    n_checks++;
    if (!ok || load_cnt !== 208) $display("FAIL l200_loads: ok %b loads %0d required 208", ok, load_cnt);
    else n_pass++;
    n_checks++;
    if (count_word_diffs() !== 0) $display("FAIL l200_words: %0d wrong words required 0", count_word_diffs());
    else n_pass++;
    n_checks++;
    if (stab_err - s0 !== 0 || both_err - b0 !== 0)
      $display("FAIL l200_hold: unstable %0d overlap %0d required 0 0", stab_err - s0, both_err - b0);
    else n_pass++;
    n_checks++;
    if (digest !== exp_digest) $display("FAIL l200_digest: got %h required %h", digest, exp_digest);
    else n_pass++;
    stall_mode = 1'b0; gap_mode = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int i0 = init_cnt;
    feed_len = 20;
    @(negedge clk);
    msg_words = LEN_W'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !(init_cnt > i0 && load_cnt >= 5); cyc++) @(negedge clk);
    n_checks++;
    if (load_cnt < 5 || dbg_state !== ST_MSG) $display("FAIL mid_reach: loads %0d state %0d required >=5 MSG", load_cnt, dbg_state);
    else n_pass++;
    #2 reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, in_ready, core_init, core_load, core_fetch} !== 6'b0 || dbg_state !== ST_IDLE)
      $display("FAIL mid_reset_ctrl: got %b state %0d required 000000 IDLE", {busy, done, in_ready, core_init, core_load, core_fetch}, dbg_state);
    else n_pass++;
    n_checks++;
    if (core_idata !== 32'h0 || digest !== 256'h0)
      $display("FAIL mid_reset_data: idata %h digest %h required zero", core_idata, digest);
    else n_pass++;
    reset_n = 1'b1;
    feed_len = 0;
    build_expected(0);
    drive_hash(0, -1, ok);
    n_checks++;
    if (!ok || digest !== EMPTY_DIGEST) $display("FAIL mid_after: ok %b digest %h required %h", ok, digest, EMPTY_DIGEST);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int i0 = init_cnt, d0 = done_cnt;
    for (int i = 0; i < 8; i++) msg_mem[i] = 32'hC0DE_0000 + 32'(i);
    stall_mode = 1'b1;
    build_expected(8);
    drive_hash(8, 3, ok);
    stall_mode = 1'b0;
    n_checks++;
    if (!ok || init_cnt - i0 !== 1 || done_cnt - d0 !== 1)
      $display("FAIL busy_start: ok %b inits %0d dones %0d required 1 1", ok, init_cnt - i0, done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (load_cnt !== 16 || digest !== exp_digest)
      $display("FAIL busy_digest: loads %0d digest %h required 16 %h", load_cnt, digest, exp_digest);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i0 = init_cnt;
    for (int i = 0; i < 3; i++) msg_mem[i] = 32'h6162_6300 + 32'(i);
    build_expected(3);
    drive_hash(3, -1, ok);
    n_checks++;
    if (!ok || digest !== exp_digest) $display("FAIL b2b_first: ok %b digest %h required %h", ok, digest, exp_digest);
    else n_pass++;
    build_expected(0);
    drive_hash(0, -1, ok);
    n_checks++;
    if (!ok || digest !== EMPTY_DIGEST || init_cnt - i0 !== 2)
      $display("FAIL b2b_second: ok %b inits %0d digest %h required 2 %h", ok, init_cnt - i0, digest, EMPTY_DIGEST);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) msg_mem[i] = '0;
    test_reset();
    test_empty();
    test_len8();
    test_block_boundary();
    test_long_stalls();
    test_mid_reset();
    test_start_while_busy();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
